// File: rtl/imem_loader.sv
// imem_loader: byte-stream boot loader that fills the instruction RAM and holds the CPU until done
// Ports: clk, reset (async, active-high); start/word_count begin a load;
//        byte_in/byte_valid/byte_ready form the byte-stream handshake;
//        imem_we/imem_waddr/imem_wdata drive the RAM write port; busy/done/cpu_hold report status.
module imem_loader #(
  parameter int N     = 32,
  parameter int AW    = 6,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   word_count,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [N-1:0]  imem_wdata,
  output logic          busy,
  output logic          done,
  output logic          cpu_hold
);
  localparam int NB = N / 8;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
  state_t state, nxt;
  logic [AW:0] cnt, written, clamp;
  logic [AW-1:0] addr;
  logic [BW-1:0] byte_idx;
  logic [N-1:0] asm_word, word_next;
  logic go, last;
  assign clamp = word_count > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : word_count;
  assign go = start && (state == IDLE || state == DONE);
  assign last = byte_idx == BW'(NB - 1);
  assign byte_ready = state == RECV;
  assign imem_we = state == WRITE;
  assign busy = state == RECV || state == WRITE;
  assign done = state == DONE;
  assign cpu_hold = state != DONE;
  always_comb begin
    word_next = asm_word;
    word_next[{byte_idx, 3'b000} +: 8] = byte_in;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: nxt = start ? (clamp == '0 ? DONE : RECV) : state;
      RECV:       nxt = (byte_valid && last) ? WRITE : RECV;
      default:    nxt = (written + 1'b1 == cnt) ? DONE : RECV;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      written <= '0;
      addr <= '0;
      byte_idx <= '0;
      asm_word <= '0;
      imem_waddr <= '0;
      imem_wdata <= '0;
    end else begin
      if (go) begin
        cnt <= clamp;
        written <= '0;
        addr <= '0;
        byte_idx <= '0;
        asm_word <= '0;
      end
      if (state == RECV && byte_valid) begin
        asm_word <= word_next;
        byte_idx <= last ? '0 : byte_idx + 1'b1;
        if (last) begin
          imem_wdata <= word_next;
          imem_waddr <= addr;
        end
      end
      if (state == WRITE) begin
        addr <= addr + 1'b1;
        written <= written + 1'b1;
        byte_idx <= '0;
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader against a write-list reference model
module tb_imem_loader;
  logic clk = 0, reset = 1, start = 0, byte_valid = 0;
  logic [6:0] word_count = 0;
  logic [7:0] byte_in = 0;
  logic byte_ready, imem_we, busy, done, cpu_hold;
  logic [5:0] imem_waddr;
  logic [31:0] imem_wdata;
  int checks = 0, failures = 0;
  typedef struct {logic [5:0] a; logic [31:0] d;} wr_t;
  wr_t obs[$], exp_q[$];
  logic prev_we = 0;

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      obs.push_back('{imem_waddr, imem_wdata});
      checks++;
      if (prev_we === 1'b1) begin
        failures++;
        $display("FAIL we_consecutive: imem_we high two cycles in a row at addr %0d", imem_waddr);
      end
      checks++;
      if (byte_ready !== 1'b0) begin
        failures++;
        $display("FAIL ready_in_write: byte_ready=%b required 0", byte_ready);
      end
    end
    prev_we = imem_we;
  end

  task automatic do_start(input int wc);
    word_count = 7'(wc);
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    byte_valid = 0;
    repeat (gap) begin @(posedge clk); #1; end
    byte_in = b;
    byte_valid = 1;
    do begin @(negedge clk); t++; end while (byte_ready !== 1'b1 && t < 100);
    if (t >= 100) begin
      failures++;
      $display("FAIL handshake_timeout: byte_ready stayed %b for 100 cycles", byte_ready);
    end
    @(posedge clk); #1;
    byte_valid = 0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], int'($urandom_range(0, maxgap)));
  endtask

  task automatic wait_done(output bit ok);
    int t = 0;
    do begin @(negedge clk); t++; end while (done !== 1'b1 && t < 5000);
    ok = done === 1'b1;
  endtask

  task automatic model(input int wc, input logic [31:0] words[$]);
    int n = wc > 64 ? 64 : wc;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back('{6'(i), words[i]});
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({byte_ready, imem_we, imem_waddr, imem_wdata, busy, done, cpu_hold} !== {1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_values: ready=%b we=%b waddr=%0d wdata=%h busy=%b done=%b hold=%b required 0 0 0 0 0 0 1",
               byte_ready, imem_we, imem_waddr, imem_wdata, busy, done, cpu_hold);
    end
    reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    obs.delete();
    do_start(1);
    checks++;
    if (busy !== 1'b1 || cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL single_busy: busy=%b hold=%b required 1 1", busy, cpu_hold);
    end
    send_word(32'hF8000001, 0);
    @(negedge clk);
    checks++;
    if (imem_we !== 1'b1 || imem_waddr !== 6'd0 || imem_wdata !== 32'hF8000001) begin
      failures++;
      $display("FAIL single_latency: we=%b waddr=%0d wdata=%h required 1 0 f8000001", imem_we, imem_waddr, imem_wdata);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_done: done=%b hold=%b busy=%b required 1 0 0", done, cpu_hold, busy);
    end
    checks++;
    if (obs.size() != 1) begin
      failures++;
      $display("FAIL single_count: writes=%0d required 1", obs.size());
    end
  endtask

  task automatic test_gaps();
    logic [31:0] w[$] = '{32'hF8000001, 32'hF8008002, 32'hF8000203};
    bit ok;
    obs.delete();
    model(3, w);
    do_start(3);
    foreach (w[i]) send_word(w[i], 5);
    wait_done(ok);
    checks++;
    if (!ok || obs.size() != exp_q.size()) begin
      failures++;
      $display("FAIL gaps_count: done=%b writes=%0d required 1 %0d", ok, obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL gaps_write%0d: addr=%0d data=%h required addr=%0d data=%h", i, obs[i].a, obs[i].d, exp_q[i].a, exp_q[i].d);
      end
    end
  endtask

  task automatic test_bounds();
    logic [31:0] w[$];
    bit ok;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    obs.delete();
    do_start(0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL zero_done: done=%b hold=%b required 1 0", done, cpu_hold);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (obs.size() != 0) begin
      failures++;
      $display("FAIL zero_writes: writes=%0d required 0", obs.size());
    end
    for (int i = 0; i < 64; i++) w.push_back($urandom);
    model(100, w);
    obs.delete();
    do_start(100);
    foreach (w[i]) send_word(w[i], 0);
    wait_done(ok);
    checks++;
    if (!ok || obs.size() != 64) begin
      failures++;
      $display("FAIL clamp_count: done=%b writes=%0d required 1 64", ok, obs.size());
    end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL clamp_write%0d: addr=%0d data=%h required addr=%0d data=%h", i, obs[i].a, obs[i].d, exp_q[i].a, exp_q[i].d);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w0 = $urandom, w1 = $urandom;
    bit ok;
    obs.delete();
    do_start(2);
    send_word(w0, 1);
    send_byte(w1[7:0], 1);
    send_byte(w1[15:8], 1);
    reset = 1;
    #1;
    checks++;
    if ({byte_ready, imem_we, imem_waddr, imem_wdata, busy, done, cpu_hold} !== {1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL midreset_values: ready=%b we=%b waddr=%0d wdata=%h busy=%b done=%b hold=%b required 0 0 0 0 0 0 1",
               byte_ready, imem_we, imem_waddr, imem_wdata, busy, done, cpu_hold);
    end
    @(posedge clk); #1;
    reset = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs.size() != 1 || obs[0] !== '{6'd0, w0}) begin
      failures++;
      $display("FAIL midreset_writes: writes=%0d required 1 (addr 0 data %h)", obs.size(), w0);
    end
    obs.delete();
    do_start(1);
    send_byte(8'hAA, 2);
    send_byte(8'hBB, 2);
    send_byte(8'hCC, 2);
    send_byte(8'hDD, 2);
    wait_done(ok);
    checks++;
    if (!ok || obs.size() != 1 || obs[0] !== '{6'd0, 32'hDDCCBBAA}) begin
      failures++;
      $display("FAIL midreset_reload: done=%b writes=%0d data=%h required 1 1 ddccbbaa", ok, obs.size(),
               obs.size() > 0 ? obs[0].d : 32'h0);
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] w[$];
    logic [31:0] w2 = $urandom;
    bit ok;
    w.push_back($urandom);
    w.push_back($urandom);
    model(2, w);
    obs.delete();
    do_start(2);
    send_byte(w[0][7:0], 1);
    send_byte(w[0][15:8], 1);
    do_start(5);
    send_byte(w[0][23:16], 1);
    send_byte(w[0][31:24], 1);
    send_word(w[1], 3);
    wait_done(ok);
    checks++;
    if (!ok || obs.size() != 2) begin
      failures++;
      $display("FAIL recv_start_count: done=%b writes=%0d required 1 2", ok, obs.size());
    end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL recv_start_write%0d: addr=%0d data=%h required addr=%0d data=%h", i, obs[i].a, obs[i].d, exp_q[i].a, exp_q[i].d);
      end
    end
    obs.delete();
    do_start(1);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cpu_hold !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL done_restart: done=%b hold=%b busy=%b required 0 1 1", done, cpu_hold, busy);
    end
    @(posedge clk); #1;
    send_word(w2, 2);
    wait_done(ok);
    checks++;
    if (!ok || obs.size() != 1 || obs[0] !== '{6'd0, w2}) begin
      failures++;
      $display("FAIL done_restart_write: done=%b writes=%0d required 1 1 (addr 0 data %h)", ok, obs.size(), w2);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gaps();
    test_bounds();
    test_reset_mid();
    test_start_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
